px_out_fifo: RTL
================

Name: px_out_fifo

Overview:
- Small elastic buffer between the gray/Sobel pipeline output (out_pixel_o / px_rdy_o) and the SPI output path (output_px_sobel_i / px_rdy_o_spi_i).
- Absorbs bursts of single-cycle pixel-ready pulses while the SPI master is still shifting out the previous pixel.
- Presents the oldest pixel with a valid level and a one-cycle "new word" pulse.
- Reports overflow and counts dropped pixels, so bench software can detect SPI under-run of the read side.

Parameters:
- DATA_WIDTH, 24: pixel word width; matches MAX_PIXEL_BITS.
- DEPTH, 4: number of entries; must be a power of two, at least 2.
- DROP_CNT_W, 8: width of the saturating dropped-pixel counter.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- nreset_i  in  1  asynchronous, active-low reset.
- wr_rdy_i  in  1  write strobe; one-cycle pulse from the pipeline's px_rdy_o.
- wr_data_i  in  DATA_WIDTH  pixel word, sampled when wr_rdy_i=1.
- rd_ack_i  in  1  consumer has taken the head word; pop when rd_valid_o=1.
- flush_i  in  1  synchronous clear of contents and status.
- rd_data_o  out  DATA_WIDTH  head word; stable while rd_valid_o=1 and no pop occurs.
- rd_valid_o  out  1  level; FIFO not empty.
- rd_rdy_o  out  1  one-cycle pulse in the first cycle a new head word is valid.
- level_o  out  $clog2(DEPTH+1)  current occupancy.
- full_o  out  1  level_o==DEPTH.
- overflow_o  out  1  sticky; set by a dropped write.
- drop_cnt_o  out  DROP_CNT_W  saturating count of dropped writes.

Behaviour:
- Reset and interface:
  - One clock, clk_i. Reset nreset_i is asynchronous and active-low.
  - On reset: pointers=0, level_o=0, rd_valid_o=0, rd_rdy_o=0, full_o=0, overflow_o=0, drop_cnt_o=0.
  - rd_data_o=0 after reset. Storage is not required to be cleared, but rd_data_o must read 0 while empty out of reset.
  - Reset asserted mid-operation discards all contents immediately; no partial pop or push completes.
- Storage:
  - Register array indexed by wr_ptr/rd_ptr of width $clog2(DEPTH); pointers wrap modulo DEPTH.
  - Occupancy is held in a count register.
- Push/pop rules:
  - push = wr_rdy_i & (~full | pop).
  - pop = rd_ack_i & rd_valid_o.
  - rd_ack_i while empty is ignored and produces no status change.
  - wr_rdy_i while full with no pop: word is dropped, overflow_o<=1, drop_cnt_o increments, saturating at all-ones.
  - Simultaneous push and pop when full: both take effect, level unchanged, no drop.
  - Simultaneous push and pop when level==1: head advances to the new word, rd_valid_o stays 1, and rd_rdy_o pulses next cycle.
- Outputs:
  - rd_valid_o and full_o are decoded from the registered count.
  - rd_data_o = mem[rd_ptr] while valid.
  - rd_rdy_o is registered: rd_rdy_o <= (count_next!=0) & ((count==0) | pop).
- Latency:
  - Push into empty at cycle T: rd_valid_o=1 and rd_rdy_o=1 at T+1.
  - Pop at T with words remaining: next word on rd_data_o at T+1, with a rd_rdy_o pulse at T+1.
  - Never two consecutive rd_rdy_o pulses without an intervening pop.
- flush_i:
  - Has priority over push and pop in the same cycle.
  - Next cycle: count=0, pointers=0, overflow_o=0, drop_cnt_o=0, rd_rdy_o=0.
  - The write presented during the flush cycle is discarded and not counted as a drop.
- Ordering: strict FIFO; words are never reordered or duplicated.

Test Plan:
- Reset, then check idle state → level_o=0, rd_valid_o=0, rd_rdy_o=0, rd_data_o=0, overflow_o=0, drop_cnt_o=0.
- Push 0x000011 at T → at T+1 rd_valid_o=1, rd_rdy_o=1 for one cycle, rd_data_o=0x000011. Then rd_ack_i at T+3 → T+4 rd_valid_o=0, no rd_rdy_o pulse.
- Push 0x0000A1..0x0000A6 on consecutive cycles with no ack (DEPTH=4) → full_o=1, level_o=4, overflow_o=1, drop_cnt_o=2. Four acks return A1, A2, A3, A4 in order, each followed by a rd_rdy_o pulse except after the last.
- Full FIFO, push 0x0000B0 together with rd_ack_i → level_o stays 4, no drop, 0x0000B0 is read fourth.
- Push 257 extra words while full (DROP_CNT_W=8) → drop_cnt_o=255, saturated. Then flush_i together with wr_rdy_i → next cycle level_o=0, overflow_o=0, drop_cnt_o=0, flushed write absent.
- Two words loaded, nreset_i pulsed low asynchronously between clock edges → all outputs return to reset values immediately, and the first push after release appears at T+1 as the sole entry.

Source files
------------

// File: rtl/px_out_fifo.sv
// Elastic pixel buffer between the Sobel pipeline output and the SPI output path.
// Holds up to DEPTH words, flags the head with a level plus a one-cycle new-word pulse.
module px_out_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                         clk_i,
    input  logic                         nreset_i,
    input  logic                         wr_rdy_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic                         rd_ack_i,
    input  logic                         flush_i,
    output logic [DATA_WIDTH-1:0]        rd_data_o,
    output logic                         rd_valid_o,
    output logic                         rd_rdy_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         full_o,
    output logic                         overflow_o,
    output logic [DROP_CNT_W-1:0]        drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_rd_rdy;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic                  w_valid;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [CW-1:0]         w_count_next;

    // Handshake: the producer's wr_rdy_i is a one-cycle strobe with no back-pressure,
    // so a write while full (and not popping) is lost and counted. The consumer pops
    // by raising rd_ack_i while rd_valid_o is high; rd_ack_i on an empty FIFO is ignored.
    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == FULL_LVL);
    assign w_pop   = rd_ack_i & w_valid;
    assign w_push  = wr_rdy_i & (~w_full | w_pop);
    assign w_drop  = wr_rdy_i & w_full & ~w_pop;

    always_comb begin
        w_count_next = r_count;
        if (flush_i) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_rdy   <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_rdy   <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count  <= w_count_next;
            // Pulse only when a fresh word becomes the head: from empty, or after a pop.
            r_rd_rdy <= (w_count_next != '0) & (~w_valid | w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    // Storage is not reset; an empty FIFO masks it on rd_data_o.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wr_ptr] <= wr_data_i;
    end

    assign rd_data_o  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign rd_valid_o = w_valid;
    assign rd_rdy_o   = r_rd_rdy;
    assign level_o    = r_count;
    assign full_o     = w_full;
    assign overflow_o = r_overflow;
    assign drop_cnt_o = r_drop_cnt;

endmodule
